// File: rtl/operand_fetch_pkg.sv
// Shared CPU definitions used by the operand-fetch stage: datapath widths
// and the operand forward-select encoding.
package operand_fetch_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_sel_e;

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// One operand's bypass network: picks the youngest producer of a source
// register, and flags a match against a load still in EX.
module fwd_mux
  import operand_fetch_pkg::*;
#(
  parameter int DW = operand_fetch_pkg::DW,
  parameter int AW = operand_fetch_pkg::AW
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rf_data,
  input  logic          ex_wr_en,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_wr_addr,
  input  logic [DW-1:0] ex_wr_data,
  input  logic          mem_wr_en,
  input  logic [AW-1:0] mem_wr_addr,
  input  logic [DW-1:0] mem_wr_data,
  input  logic          wb_wr_en,
  input  logic [AW-1:0] wb_wr_addr,
  input  logic [DW-1:0] wb_wr_data,
  output logic [DW-1:0] data,
  output logic          load_match
);

  fwd_sel_e sel;

  // Register 0 is hardwired, so a producer targeting it never forwards.
  function automatic logic hit(input logic en, input logic [AW-1:0] wr_addr,
                               input logic [AW-1:0] rd_addr);
    return en && (wr_addr != '0) && (wr_addr == rd_addr);
  endfunction

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    sel = FWD_RF;
    if (addr == '0)                                    sel = FWD_ZERO;
    else if (hit(ex_wr_en && !ex_is_load, ex_wr_addr, addr)) sel = FWD_EX;
    else if (hit(mem_wr_en, mem_wr_addr, addr))        sel = FWD_MEM;
    else if (hit(wb_wr_en, wb_wr_addr, addr))          sel = FWD_WB;
  end

  always_comb begin
    data = rf_data;
    case (sel)
      FWD_ZERO: data = '0;
      FWD_EX:   data = ex_wr_data;
      FWD_MEM:  data = mem_wr_data;
      FWD_WB:   data = wb_wr_data;
      default:  data = rf_data;
    endcase
  end

  assign load_match = hit(ex_wr_en && ex_is_load, ex_wr_addr, addr);

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads the register file, resolves bypasses, stalls on
// load-use hazards and holds the result in a single ready/valid output register.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DW = operand_fetch_pkg::DW,
  parameter int AW = operand_fetch_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_wr_addr,
  input  logic          in_wr_en,
  input  logic          in_is_load,
  output logic [AW-1:0] rf_r1_addr,
  output logic [AW-1:0] rf_r2_addr,
  input  logic [DW-1:0] rf_r1_data,
  input  logic [DW-1:0] rf_r2_data,
  input  logic          ex_wr_en,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_wr_addr,
  input  logic [DW-1:0] ex_wr_data,
  input  logic          mem_wr_en,
  input  logic [AW-1:0] mem_wr_addr,
  input  logic [DW-1:0] mem_wr_data,
  input  logic          wb_wr_en,
  input  logic [AW-1:0] wb_wr_addr,
  input  logic [DW-1:0] wb_wr_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_op_a,
  output logic [DW-1:0] out_op_b,
  output logic [AW-1:0] out_wr_addr,
  output logic          out_wr_en,
  output logic          out_is_load,
  output logic [15:0]   stall_cnt
);

  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          load_match_a;
  logic          load_match_b;
  logic          hazard;
  logic          capture;
  logic          stall;

  assign rf_r1_addr = in_rs;
  assign rf_r2_addr = in_rt;

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
    .addr        (in_rs),
    .rf_data     (rf_r1_data),
    .ex_wr_en    (ex_wr_en),
    .ex_is_load  (ex_is_load),
    .ex_wr_addr  (ex_wr_addr),
    .ex_wr_data  (ex_wr_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .wb_wr_en    (wb_wr_en),
    .wb_wr_addr  (wb_wr_addr),
    .wb_wr_data  (wb_wr_data),
    .data        (op_a),
    .load_match  (load_match_a)
  );

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
    .addr        (in_rt),
    .rf_data     (rf_r2_data),
    .ex_wr_en    (ex_wr_en),
    .ex_is_load  (ex_is_load),
    .ex_wr_addr  (ex_wr_addr),
    .ex_wr_data  (ex_wr_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .wb_wr_en    (wb_wr_en),
    .wb_wr_addr  (wb_wr_addr),
    .wb_wr_data  (wb_wr_data),
    .data        (op_b),
    .load_match  (load_match_b)
  );

  // A flush squashes the requester anyway, so it neither stalls nor counts.
  assign hazard   = in_valid && (load_match_a || load_match_b) && !flush;
  assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
  assign capture  = in_valid && in_ready;
  assign stall    = in_valid && !in_ready && !flush;

  // NOTE: state uses non-blocking assignments and an asynchronous active-low reset branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_op_a    <= '0;
      out_op_b    <= '0;
      out_wr_addr <= '0;
      out_wr_en   <= 1'b0;
      out_is_load <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_op_a    <= op_a;
      out_op_b    <= op_b;
      out_wr_addr <= in_wr_addr;
      out_wr_en   <= in_wr_en;
      out_is_load <= in_is_load;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: forwarding table, directed stall /
// hold / flush / reset sequences, then random traffic against a pipeline model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_wr_addr;
  logic        in_wr_en, in_is_load;
  logic [4:0]  rf_r1_addr, rf_r2_addr;
  logic [31:0] rf_r1_data, rf_r2_data;
  logic        ex_wr_en, ex_is_load;
  logic [4:0]  ex_wr_addr;
  logic [31:0] ex_wr_data;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        wb_wr_en;
  logic [4:0]  wb_wr_addr;
  logic [31:0] wb_wr_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_op_a, out_op_b;
  logic [4:0]  out_wr_addr;
  logic        out_wr_en, out_is_load;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  logic [31:0] rf_mem [32];
  assign rf_r1_data = rf_mem[rf_r1_addr];
  assign rf_r2_data = rf_mem[rf_r2_addr];

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_wr_addr(in_wr_addr),
    .in_wr_en(in_wr_en), .in_is_load(in_is_load),
    .rf_r1_addr(rf_r1_addr), .rf_r2_addr(rf_r2_addr),
    .rf_r1_data(rf_r1_data), .rf_r2_data(rf_r2_data),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_wr_addr(out_wr_addr), .out_wr_en(out_wr_en), .out_is_load(out_is_load),
    .stall_cnt(stall_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state of the stage's output register and stall counter.
  logic        m_valid, m_we, m_ld;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_wa;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Youngest in-flight writer of a register wins; loads in EX have no data yet.
  function automatic logic [31:0] ref_op(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (ex_wr_en && !ex_is_load && ex_wr_addr == a) return ex_wr_data;
    if (mem_wr_en && mem_wr_addr == a) return mem_wr_data;
    if (wb_wr_en && wb_wr_addr == a) return wb_wr_data;
    return rf_mem[a];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_we = 1'b0; m_ld = 1'b0;
    m_a = '0; m_b = '0; m_wa = '0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    check({tag, "_op_a"}, out_op_a, m_a);
    check({tag, "_op_b"}, out_op_b, m_b);
    check({tag, "_wr_addr"}, {27'd0, out_wr_addr}, {27'd0, m_wa});
    check({tag, "_wr_en"}, {31'd0, out_wr_en}, {31'd0, m_we});
    check({tag, "_is_load"}, {31'd0, out_is_load}, {31'd0, m_ld});
    check({tag, "_stall_cnt"}, {16'd0, stall_cnt}, m_cnt[31:0]);
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic step(input string tag);
    logic haz, rdy, take;
    haz = in_valid && !flush && ex_wr_en && ex_is_load && ex_wr_addr != 5'd0 &&
          (ex_wr_addr == in_rs || ex_wr_addr == in_rt);
    rdy = !haz && (!m_valid || out_ready) && !flush;
    take = in_valid && rdy;
    #1;
    check({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    check({tag, "_rf_r1_addr"}, {27'd0, rf_r1_addr}, {27'd0, in_rs});
    check({tag, "_rf_r2_addr"}, {27'd0, rf_r2_addr}, {27'd0, in_rt});
    if (in_valid && !rdy && !flush && m_cnt < 65535) m_cnt++;
    if (flush) m_valid = 1'b0;
    else if (take) begin
      m_valid = 1'b1;
      m_a = ref_op(in_rs); m_b = ref_op(in_rt);
      m_wa = in_wr_addr; m_we = in_wr_en; m_ld = in_is_load;
    end else if (m_valid && out_ready) m_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic clear_bypass();
    ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = 0; ex_wr_data = 0;
    mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 0;
    wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 0;
  endtask

  typedef struct {
    logic [4:0]  rs, rt;
    logic        ex_en, ex_ld;
    logic [4:0]  ex_a;
    logic [31:0] ex_d;
    logic        mem_en;
    logic [4:0]  mem_a;
    logic [31:0] mem_d;
    logic        wb_en;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [31:0] hold_a, hold_b;

    tbl[0] = '{5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h22,
               1'b1, 5'd3, 32'h33, 32'h22, 32'hA000_0004};
    tbl[1] = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,
               1'b0, 5'd0, 32'h0, 32'h0, 32'h0};
    tbl[2] = '{5'd7, 5'd7, 1'b1, 1'b0, 5'd7, 32'h77, 1'b1, 5'd7, 32'h88,
               1'b1, 5'd7, 32'h99, 32'h77, 32'h77};
    tbl[3] = '{5'd7, 5'd8, 1'b1, 1'b0, 5'd0, 32'hDEAD, 1'b1, 5'd8, 32'h88,
               1'b1, 5'd7, 32'h99, 32'h99, 32'h88};
    tbl[4] = '{5'd9, 5'd10, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 32'h5555,
               1'b1, 5'd10, 32'h1010, 32'hA000_0009, 32'h1010};
    tbl[5] = '{5'd12, 5'd12, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0C0,
               1'b1, 5'd0, 32'h5, 32'hC0C0, 32'hC0C0};
    tbl[6] = '{5'd31, 5'd1, 1'b1, 1'b0, 5'd31, 32'h31, 1'b0, 5'd0, 32'h0,
               1'b0, 5'd0, 32'h0, 32'h31, 32'hA000_0001};
    tbl[7] = '{5'd2, 5'd3, 1'b1, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0,
               1'b0, 5'd0, 32'h0, 32'hA000_0002, 32'h11};

    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000_0000 | i;
    rf_mem[3] = 32'h11;

    rst = 0; in_valid = 0; in_rs = 0; in_rt = 0; in_wr_addr = 0;
    in_wr_en = 0; in_is_load = 0; flush = 0; out_ready = 1;
    clear_bypass();
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1;

    // Forwarding priority table
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; out_ready = 1;
      in_rs = tbl[i].rs; in_rt = tbl[i].rt;
      in_wr_addr = 5'(i + 16); in_wr_en = 1'b1; in_is_load = i[0];
      ex_wr_en = tbl[i].ex_en; ex_is_load = tbl[i].ex_ld;
      ex_wr_addr = tbl[i].ex_a; ex_wr_data = tbl[i].ex_d;
      mem_wr_en = tbl[i].mem_en; mem_wr_addr = tbl[i].mem_a; mem_wr_data = tbl[i].mem_d;
      wb_wr_en = tbl[i].wb_en; wb_wr_addr = tbl[i].wb_a; wb_wr_data = tbl[i].wb_d;
      step($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_exp_a", i), out_op_a, tbl[i].exp_a);
      check($sformatf("tbl%0d_exp_b", i), out_op_b, tbl[i].exp_b);
    end

    // Load-use hazard: bubble, one stall, then capture once the load moves on
    clear_bypass();
    in_valid = 1; out_ready = 1; in_rs = 5'd2; in_rt = 5'd5; in_wr_addr = 5'd9;
    ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd5; ex_wr_data = 32'hBAD;
    #1 check("haz_in_ready", {31'd0, in_ready}, 32'd0);
    step("haz");
    check("haz_bubble", {31'd0, out_valid}, 32'd0);
    check("haz_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    clear_bypass();
    step("haz_clear");
    check("haz_captured", {31'd0, out_valid}, 32'd1);
    check("haz_captured_wa", {27'd0, out_wr_addr}, 32'd9);
    check("haz_captured_b", out_op_b, 32'hA000_0005);

    // Downstream back-pressure for three cycles
    hold_a = m_a; hold_b = m_b;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_rs = 5'(i + 20); in_rt = 5'(i + 24); in_wr_addr = 5'(i);
      #1 check($sformatf("hold%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      step($sformatf("hold%0d", i));
      check($sformatf("hold%0d_a", i), out_op_a, hold_a);
      check($sformatf("hold%0d_b", i), out_op_b, hold_b);
    end
    check("hold_stall_cnt", {16'd0, stall_cnt}, 32'd4);

    // Flush overrides hold and is not counted as a stall
    flush = 1;
    #1 check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    step("flush");
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_stall_cnt", {16'd0, stall_cnt}, 32'd4);
    flush = 0;

    // Reset in the middle of a stall
    step("pre_rst_cap");
    step("pre_rst_stall");
    rst = 0;
    model_reset();
    #1;
    check_outputs("rst_async");
    check("rst_stall_zero", {16'd0, stall_cnt}, 32'd0);
    @(posedge clk);
    #1 check_outputs("rst_held");
    @(negedge clk);
    rst = 1; out_ready = 1; in_valid = 1; in_rs = 5'd6; in_rt = 5'd0;
    step("post_rst");
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    for (int i = 0; i < 400; i++) begin
      rf_mem[$urandom_range(1, 31)] = $urandom;
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_rs = 5'($urandom_range(0, 3)); in_rt = 5'($urandom_range(0, 3));
      in_wr_addr = 5'($urandom); in_wr_en = 1'($urandom); in_is_load = 1'($urandom);
      ex_wr_en = 1'($urandom); ex_is_load = 1'($urandom_range(0, 3) == 0);
      ex_wr_addr = 5'($urandom_range(0, 3)); ex_wr_data = $urandom;
      mem_wr_en = 1'($urandom); mem_wr_addr = 5'($urandom_range(0, 3)); mem_wr_data = $urandom;
      wb_wr_en = 1'($urandom); wb_wr_addr = 5'($urandom_range(0, 3)); wb_wr_data = $urandom;
      flush = 1'($urandom_range(0, 9) == 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      step($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
